// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and a
// clog2 variant that never returns zero, for sizing index/count fields.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_STRETCH = 2'd2,
    ST_ARMED   = 2'd3
  } rst_state_t;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_down_counter.sv
// Loadable down-counter shared by the stretch and replay-delay phases.
// zero_next flags the last counted cycle (count == 1).
module rst_down_counter #(
  parameter int CNT_W   = 24,
  parameter int RST_VAL = 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_next
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: load wins over decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      count_q <= CNT_W'(RST_VAL);
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_next = (count_q == CNT_W'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Merges level reset requests into one stretched core reset and optionally
// re-issues delayed replay resets after replay-masked sources release.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int STRETCH      = 1000,
  parameter int REPLAY_DELAY = 5000000,
  parameter int NUM_REPLAY   = 1,
  parameter int CNT_W        = 24
) (
  input  logic                             clk_sys,
  input  logic                             reset,
  input  logic [NUM_SRC-1:0]               src_req,
  input  logic [NUM_SRC-1:0]               src_replay,
  input  logic                             replay_en,
  output logic                             core_reset,
  output logic                             busy,
  output logic                             replay_pending,
  output logic [clog2_min1(NUM_SRC)-1:0]   last_src,
  output logic [7:0]                       reset_count
);

  localparam int LS_W = clog2_min1(NUM_SRC);
  localparam int RL_W = clog2_min1(NUM_REPLAY + 1);

  rst_state_t       state_d, state_q;
  logic [NUM_SRC-1:0] src_q;
  logic             arm_d, arm_q;
  logic [RL_W-1:0]  replay_left_d, replay_left_q;
  logic [LS_W-1:0]  last_src_d, last_src_q;
  logic [LS_W-1:0]  lowest_idx;
  logic [7:0]       reset_count_d, reset_count_q;
  logic             core_reset_d, core_reset_q;
  logic             busy_q, replay_pending_q;
  logic             any_req, hit_replay;
  logic             cnt_load, cnt_dec, cnt_zero_next;
  logic [CNT_W-1:0] cnt_val;

  assign any_req    = |src_q;
  assign hit_replay = |(src_q & src_replay);

  // Lowest-index active request; scanning downward lets the lowest win.
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      lowest_idx = src_q[i] ? LS_W'(i) : lowest_idx;
    end
  end

  // Next-state, counter control and output decode.
  always_comb begin
    state_d       = state_q;
    arm_d         = any_req ? (arm_q | hit_replay) : arm_q;
    replay_left_d = replay_left_q;
    last_src_d    = last_src_q;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    cnt_val       = CNT_W'(STRETCH);
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d    = ST_HOLD;
          last_src_d = lowest_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!any_req) begin
          state_d  = ST_STRETCH;
          cnt_load = 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_STRETCH: begin
        // A request arriving on the final count takes precedence, so the
        // reset never drops for a cycle in between.
        if (any_req) begin
          state_d    = ST_HOLD;
          last_src_d = lowest_idx;
        end else if (cnt_zero_next) begin
          if (arm_q && replay_en && (replay_left_q != '0)) begin
            state_d  = ST_ARMED;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(REPLAY_DELAY);
          end else begin
            state_d       = ST_IDLE;
            arm_d         = 1'b0;
            replay_left_d = RL_W'(NUM_REPLAY);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_ARMED: begin
        if (any_req) begin
          state_d       = ST_HOLD;
          last_src_d    = lowest_idx;
          replay_left_d = RL_W'(NUM_REPLAY);
        end else if (!replay_en) begin
          state_d       = ST_IDLE;
          arm_d         = 1'b0;
          replay_left_d = RL_W'(NUM_REPLAY);
        end else if (cnt_zero_next) begin
          state_d       = ST_STRETCH;
          cnt_load      = 1'b1;
          replay_left_d = replay_left_q - RL_W'(1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        arm_d         = 1'b0;
        replay_left_d = RL_W'(NUM_REPLAY);
      end
    endcase

    core_reset_d = (state_d == ST_HOLD) || (state_d == ST_STRETCH);
    if (core_reset_d && !core_reset_q && (reset_count_q != 8'hFF)) begin
      reset_count_d = reset_count_q + 8'd1;
    end else begin
      reset_count_d = reset_count_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q          <= ST_STRETCH;
      src_q            <= '0;
      arm_q            <= 1'b0;
      replay_left_q    <= RL_W'(NUM_REPLAY);
      last_src_q       <= '0;
      reset_count_q    <= 8'd0;
      core_reset_q     <= 1'b1;
      busy_q           <= 1'b1;
      replay_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      src_q            <= src_req;
      arm_q            <= arm_d;
      replay_left_q    <= replay_left_d;
      last_src_q       <= last_src_d;
      reset_count_q    <= reset_count_d;
      core_reset_q     <= core_reset_d;
      busy_q           <= (state_d != ST_IDLE);
      replay_pending_q <= (state_d == ST_ARMED);
    end
  end

  rst_down_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL (STRETCH)
  ) u_counter (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .load      (cnt_load),
    .load_val  (cnt_val),
    .dec       (cnt_dec),
    .zero_next (cnt_zero_next)
  );

  assign core_reset     = core_reset_q;
  assign busy           = busy_q;
  assign replay_pending = replay_pending_q;
  assign last_src       = last_src_q;
  assign reset_count    = reset_count_q;

endmodule
